// File: rtl/cpu_types_pkg.sv
//------------------------------------------------------------------------------
// Module : cpu_types_pkg
// Brief  : Shared CPU/memory types, including the RAM handshake and arbiter states.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_D    = 2'd1,
        ARB_I    = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter.sv
//------------------------------------------------------------------------------
// Module : mem_arbiter
// Brief  : Single-port RAM arbiter between icache fetch and dcache traffic,
//          with dcache block lock and icache anti-starvation.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  word_t       iaddr,
    output word_t       iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  word_t       daddr,
    input  word_t       dstore,
    output word_t       dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output word_t       ramaddr,
    output word_t       ramstore,
    input  word_t       ramload,
    input  ramstate_t   ramstate,
    output logic        err
);

    localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);

    arb_state_t      state_q, state_d;
    logic [CW-1:0]   starve_cnt_q, starve_cnt_d;
    logic            dlock_q, dlock_d;
    logic            last_d_q, last_d_d;
    logic            err_q, err_d;

    logic            w_dreq;
    logic            w_done;

    assign w_dreq = dREN | dWEN;
    assign w_done = (ramstate == ACCESS) || (ramstate == ERROR);
    assign err    = err_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= ARB_IDLE;
            starve_cnt_q <= '0;
            dlock_q      <= 1'b0;
            last_d_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            dlock_q      <= dlock_d;
            last_d_q     <= last_d_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        dlock_d      = dlock_q;
        last_d_d     = last_d_q;
        err_d        = err_q;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        iwait        = 1'b1;
        dwait        = 1'b1;
        iload        = '0;
        dload        = '0;

        case (state_q)
            ARB_IDLE: begin
                if (dlock_q && !w_dreq) begin
                    dlock_d = 1'b0;
                end
                // Lock outranks starvation so a two-word block is never split.
                if ((dlock_q && w_dreq) || (w_dreq && !(iREN && starve_cnt_q == C_LIMIT))) begin
                    state_d  = ARB_D;
                    last_d_d = 1'b1;
                    if (iREN && starve_cnt_q != C_LIMIT) begin
                        starve_cnt_d = starve_cnt_q + CW'(1);
                    end
                end else if (iREN) begin
                    state_d      = ARB_I;
                    last_d_d     = 1'b0;
                    starve_cnt_d = '0;
                end
            end

            ARB_D: begin
                ramaddr  = daddr;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramstore = dstore;
                if (!w_dreq) begin
                    state_d = ARB_IDLE;
                end else if (w_done) begin
                    dwait   = 1'b0;
                    dload   = ramload;
                    state_d = ARB_IDLE;
                    dlock_d = ~daddr[2];
                    if (ramstate == ERROR) begin
                        err_d = 1'b1;
                    end
                end
            end

            ARB_I: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (!iREN) begin
                    state_d = ARB_IDLE;
                end else if (w_done) begin
                    iwait   = 1'b0;
                    iload   = ramload;
                    state_d = ARB_IDLE;
                    dlock_d = 1'b0;
                    if (ramstate == ERROR) begin
                        err_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_mem_arbiter
// Brief  : Directed self-checking bench for mem_arbiter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    word_t     iload, dload, ramaddr, ramstore;
    logic      iwait, dwait, ramREN, ramWEN, err;
    ramstate_t ramstate;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.STARVE_LIMIT(4), .CW(3)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed 2 units after the edge, checks 1 unit later.
    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        #12;
        check("rst_state", 32'(dut.state_q), 32'(ARB_IDLE));
        check("rst_ramren", 32'(ramREN), 32'd0);
        check("rst_iwait", 32'(iwait), 32'd1);
        check("rst_dwait", 32'(dwait), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        nRST = 1'b1;

        // icache read: BUSY, BUSY, ACCESS
        cyc();
        iREN = 1; iaddr = 32'h40; ramstate = BUSY; ramload = 32'hDEADBEEF;
        #1 check("i_idle_ramren", 32'(ramREN), 32'd0);
        cyc(); #1;
        check("i_c1_ramren", 32'(ramREN), 32'd1);
        check("i_c1_addr", ramaddr, 32'h40);
        check("i_c1_iwait", 32'(iwait), 32'd1);
        check("i_c1_iload", iload, 32'h0);
        cyc(); #1;
        check("i_c2_iwait", 32'(iwait), 32'd1);
        cyc(); ramstate = ACCESS; #1;
        check("i_acc_iwait", 32'(iwait), 32'd0);
        check("i_acc_iload", iload, 32'hDEADBEEF);
        cyc(); iREN = 0; ramstate = BUSY; #1;
        check("i_ret_idle", 32'(dut.state_q), 32'(ARB_IDLE));
        check("i_ret_iwait", 32'(iwait), 32'd1);

        // Simultaneous iREN and dWEN: D first, I after bubble
        iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h100; dstore = 32'h1234;
        cyc(); #1;
        check("dw_state", 32'(dut.state_q), 32'(ARB_D));
        check("dw_ramwen", 32'(ramWEN), 32'd1);
        check("dw_ramren", 32'(ramREN), 32'd0);
        check("dw_store", ramstore, 32'h1234);
        check("dw_addr", ramaddr, 32'h100);
        check("dw_iwait", 32'(iwait), 32'd1);
        cyc(); ramstate = ACCESS; #1;
        check("dw_done_dwait", 32'(dwait), 32'd0);
        check("dw_done_iwait", 32'(iwait), 32'd1);
        cyc(); dWEN = 0; ramstate = BUSY; #1;
        check("dw_bubble", 32'(dut.state_q), 32'(ARB_IDLE));
        check("dw_bubble_ramwen", 32'(ramWEN), 32'd0);
        cyc(); #1;
        check("dw_then_i", 32'(dut.state_q), 32'(ARB_I));
        check("dw_then_i_addr", ramaddr, 32'h80);
        cyc(); ramstate = ACCESS; ramload = 32'h0BAD_F00D; #1;
        check("dw_i_done_iload", iload, 32'h0BAD_F00D);
        cyc(); iREN = 0; #1;
        check("dw_cnt_clear", 32'(dut.starve_cnt_q), 32'd0);

        // Two-word dcache block: 0x200 then 0x204 with iREN pending
        iREN = 1; dREN = 1; daddr = 32'h200; ramstate = ACCESS; ramload = 32'h1111;
        cyc(); #1;
        check("lk_w0_state", 32'(dut.state_q), 32'(ARB_D));
        check("lk_w0_ramren", 32'(ramREN), 32'd1);
        check("lk_w0_dload", dload, 32'h1111);
        check("lk_w0_dwait", 32'(dwait), 32'd0);
        cyc(); daddr = 32'h204; ramload = 32'h2222; #1;
        check("lk_bubble_lock", 32'(dut.dlock_q), 32'd1);
        cyc(); #1;
        check("lk_w1_state", 32'(dut.state_q), 32'(ARB_D));
        check("lk_w1_addr", ramaddr, 32'h204);
        check("lk_w1_dload", dload, 32'h2222);
        cyc(); dREN = 0; #1;
        check("lk_unlock", 32'(dut.dlock_q), 32'd0);
        cyc(); #1;
        check("lk_then_i", 32'(dut.state_q), 32'(ARB_I));
        check("lk_i_iwait", 32'(iwait), 32'd0);
        cyc(); #1;

        // Starvation: 4 D grants with iREN pending, then I wins
        dREN = 1; daddr = 32'h304;
        for (int k = 1; k <= 4; k++) begin
            cyc(); #1;
            check("sv_d_state", 32'(dut.state_q), 32'(ARB_D));
            check("sv_cnt", 32'(dut.starve_cnt_q), 32'(k));
            cyc(); #1;
        end
        cyc(); #1;
        check("sv_i_state", 32'(dut.state_q), 32'(ARB_I));
        check("sv_i_iwait", 32'(iwait), 32'd0);
        check("sv_cnt_zero", 32'(dut.starve_cnt_q), 32'd0);
        cyc(); iREN = 0; dREN = 0; #1;

        // ERROR completion sets sticky err
        dREN = 1; daddr = 32'h404; ramstate = ERROR;
        cyc(); #1;
        check("er_dwait", 32'(dwait), 32'd0);
        check("er_err_pre", 32'(err), 32'd0);
        cyc(); ramstate = ACCESS; #1;
        check("er_err_set", 32'(err), 32'd1);
        cyc(); #1;
        check("er_acc_dwait", 32'(dwait), 32'd0);
        cyc(); dREN = 0; #1;
        check("er_err_sticky", 32'(err), 32'd1);

        // Asynchronous reset in the middle of a BUSY dcache grant
        iREN = 1; dREN = 1; daddr = 32'h504; ramstate = BUSY;
        cyc(); #1;
        check("ar_pre_ramren", 32'(ramREN), 32'd1);
        check("ar_pre_cnt", 32'(dut.starve_cnt_q), 32'd1);
        nRST = 0; #1;
        check("ar_ramren", 32'(ramREN), 32'd0);
        check("ar_ramwen", 32'(ramWEN), 32'd0);
        check("ar_state", 32'(dut.state_q), 32'(ARB_IDLE));
        check("ar_err", 32'(err), 32'd0);
        check("ar_cnt", 32'(dut.starve_cnt_q), 32'd0);
        check("ar_dwait", 32'(dwait), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
